// File: rtl/mem_io_ctrl_pkg.sv
// Shared types and I/O map for the memory/I-O responder on the CPU byte bus.
// The I/O window is selected by address bits [17:16].
package mem_io_ctrl_pkg;
   typedef logic [7:0]  byte_t;
   typedef logic [31:0] word_t;

   localparam word_t      IO_BASE = 32'h0003_0000;
   localparam word_t      IO_UART = 32'h0003_0000;
   localparam word_t      IO_CLK  = 32'h0003_0004;
   localparam logic [1:0] IO_SEL  = 2'b11;
endpackage

// File: rtl/mem_io_ctrl_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. Reset is synchronous and active-low.
// A push while full is accepted only if a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             push_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full_out,
   output logic             empty_out
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      empty_out = (wr_ptr_q == rd_ptr_q);
      full_out  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop    = pop_in & ~empty_out;
      do_push   = push_in & (~full_out | do_pop);
      wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, do_pop};
      // Head reads as zero when empty so the output is defined after reset
      data_out  = empty_out ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
   end
endmodule

// File: rtl/mem_io_ctrl.sv
// Memory-side responder: byte RAM below the I/O window, plus UART in/out,
// a free-running cycle counter with coherent snapshot reads, and the stop port.
module mem_io_ctrl
   import mem_io_ctrl_pkg::*;
#(
   parameter int RAM_AW   = 17,
   parameter int TX_DEPTH = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a_in,
   input  logic        mem_wr_in,
   input  logic [7:0]  mem_wdata_in,
   output logic [7:0]  mem_rdata_out,
   input  logic [7:0]  rx_data_in,
   input  logic        rx_valid_in,
   output logic        rx_ready_out,
   output logic [7:0]  tx_data_out,
   output logic        tx_valid_out,
   input  logic        tx_ready_in,
   output logic        prog_stop_out,
   output logic        tx_overflow_out
);
   byte_t ram_q [2**RAM_AW];

   word_t cnt_q, cnt_d, snap_q, snap_d;
   byte_t rdata_q, rdata_d;
   logic  stop_q, stop_d, ovf_q, ovf_d;
   logic  io_sel, uart_hit, clk_hit, act, ram_we, tx_push, tx_pop, tx_full, tx_empty;
   logic  unused_addr;

   assign unused_addr = ^mem_a_in[31:18];

   always_comb begin
      io_sel   = (mem_a_in[17:16] == IO_SEL);
      uart_hit = io_sel && (mem_a_in[15:0] == IO_UART[15:0]);
      clk_hit  = io_sel && (mem_a_in[15:2] == IO_CLK[15:2]);
      act      = rdy_in & rst_in;
      ram_we   = act & ~io_sel & mem_wr_in;
      rx_ready_out = act & uart_hit & ~mem_wr_in & rx_valid_in;
      tx_push  = act & uart_hit & mem_wr_in & (mem_wdata_in != 8'h00);
      tx_pop   = tx_valid_out & tx_ready_in;

      cnt_d   = rdy_in ? cnt_q + 32'd1 : cnt_q;
      snap_d  = snap_q;
      rdata_d = rdata_q;
      stop_d  = stop_q;
      ovf_d   = ovf_q | (tx_push & tx_full & ~tx_pop);

      if (rdy_in && !mem_wr_in) begin
         if (!io_sel) begin
            rdata_d = ram_q[mem_a_in[RAM_AW-1:0]];
         end else if (uart_hit) begin
            rdata_d = rx_valid_in ? rx_data_in : 8'h00;
         end else if (clk_hit) begin
            // The low-byte read latches the snapshot so later bytes stay coherent
            unique case (mem_a_in[1:0])
               2'd0: begin
                  rdata_d = cnt_q[7:0];
                  snap_d  = cnt_q;
               end
               2'd1: rdata_d = snap_q[15:8];
               2'd2: rdata_d = snap_q[23:16];
               default: rdata_d = snap_q[31:24];
            endcase
         end else begin
            rdata_d = 8'h00;
         end
      end

      if (rdy_in && mem_wr_in && clk_hit && (mem_a_in[1:0] == 2'd0)) stop_d = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         cnt_q   <= '0;
         snap_q  <= '0;
         rdata_q <= '0;
         stop_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         rdata_q <= rdata_d;
         stop_q  <= stop_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (ram_we) ram_q[mem_a_in[RAM_AW-1:0]] <= mem_wdata_in;
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push_in   (tx_push),
      .data_in   (mem_wdata_in),
      .pop_in    (tx_ready_in),
      .data_out  (tx_data_out),
      .full_out  (tx_full),
      .empty_out (tx_empty)
   );

   assign tx_valid_out    = ~tx_empty;
   assign mem_rdata_out   = rdata_q;
   assign prog_stop_out   = stop_q;
   assign tx_overflow_out = ovf_q;
endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl: RAM, UART in/out, counter snapshot, stop port,
// bus freeze and reset behaviour.
module tb_mem_io_ctrl;
   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] mem_a_in;
   logic        mem_wr_in;
   logic [7:0]  mem_wdata_in;
   logic [7:0]  mem_rdata_out;
   logic [7:0]  rx_data_in;
   logic        rx_valid_in;
   logic        rx_ready_out;
   logic [7:0]  tx_data_out;
   logic        tx_valid_out;
   logic        tx_ready_in;
   logic        prog_stop_out;
   logic        tx_overflow_out;

   localparam logic [31:0] IDLE_A = 32'h0001_FFFF;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  txq[$];
   logic [31:0] mcnt;
   logic [31:0] exp_cnt, got_w;

   mem_io_ctrl #(.RAM_AW(17), .TX_DEPTH(16)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .rdy_in          (rdy_in),
      .mem_a_in        (mem_a_in),
      .mem_wr_in       (mem_wr_in),
      .mem_wdata_in    (mem_wdata_in),
      .mem_rdata_out   (mem_rdata_out),
      .rx_data_in      (rx_data_in),
      .rx_valid_in     (rx_valid_in),
      .rx_ready_out    (rx_ready_out),
      .tx_data_out     (tx_data_out),
      .tx_valid_out    (tx_valid_out),
      .tx_ready_in     (tx_ready_in),
      .prog_stop_out   (prog_stop_out),
      .tx_overflow_out (tx_overflow_out)
   );

   always #5 clk_in = ~clk_in;

   // Reference cycle counter and TX sink log
   always @(posedge clk_in) begin
      if (!rst_in) mcnt <= '0;
      else if (rdy_in) mcnt <= mcnt + 32'd1;
      if (rst_in && tx_valid_out && tx_ready_in) txq.push_back(tx_data_out);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a_in     = a;
      mem_wr_in    = wr;
      mem_wdata_in = d;
   endtask

   task automatic idle(input int n);
      drive(IDLE_A, 1'b0, 8'h00);
      repeat (n) step();
   endtask

   task automatic read_clk(output logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         drive(32'h0003_0004 + k, 1'b0, 8'h00);
         step();
         w[8*k +: 8] = mem_rdata_out;
      end
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; tx_ready_in = 1'b0;
      rx_valid_in = 1'b0; rx_data_in = 8'h00;
      drive(IDLE_A, 1'b0, 8'h00);
      step(); step();
      chk("rst_rdata", mem_rdata_out, 0);
      chk("rst_txv", tx_valid_out, 0);
      chk("rst_txd", tx_data_out, 0);
      chk("rst_stop", prog_stop_out, 0);
      chk("rst_ovf", tx_overflow_out, 0);
      chk("rst_rxr", rx_ready_out, 0);

      // 255 counted edges: low byte 0xFF, snapshot keeps upper bytes at 0
      rst_in = 1'b1;
      idle(255);
      read_clk(got_w);
      chk("clk_snap255", got_w, 32'h0000_00FF);

      drive(32'h0000_0010, 1'b1, 8'hA5); step();
      drive(32'h0000_0010, 1'b0, 8'h00); step();
      chk("ram_a5", mem_rdata_out, 8'hA5);
      drive(32'h0001_FFFE, 1'b1, 8'h5A); step();
      drive(32'h0001_FFFE, 1'b0, 8'h00); step();
      chk("ram_top", mem_rdata_out, 8'h5A);
      drive(32'h0003_0008, 1'b0, 8'h00); step();
      chk("io_other", mem_rdata_out, 8'h00);

      txq.delete();
      tx_ready_in = 1'b1;
      drive(32'h0003_0000, 1'b1, 8'h41); step();
      chk("tx_v41", tx_valid_out, 1);
      chk("tx_d41", tx_data_out, 8'h41);
      drive(32'h0003_0000, 1'b1, 8'h00); step();
      chk("tx_zero_ign", tx_valid_out, 0);
      idle(3);
      chk("tx_cnt1", txq.size(), 1);
      chk("tx_byte", (txq.size() > 0) ? 32'(txq[0]) : 32'hFFFF_FFFF, 8'h41);

      tx_ready_in = 1'b0;
      txq.delete();
      for (int i = 0; i < 17; i++) begin
         drive(32'h0003_0000, 1'b1, 8'(8'h10 + i)); step();
         if (i == 15) chk("ovf_not_yet", tx_overflow_out, 0);
      end
      chk("ovf_set", tx_overflow_out, 1);
      chk("tx_hold_v", tx_valid_out, 1);
      chk("tx_hold_d", tx_data_out, 8'h10);
      idle(1);
      tx_ready_in = 1'b1;
      idle(18);
      chk("drain_cnt", txq.size(), 16);
      for (int i = 0; i < 16; i++)
         chk($sformatf("drain_%0d", i), (txq.size() > i) ? 32'(txq[i]) : 32'hFFFF_FFFF, 8'h10 + i);
      chk("drain_empty", tx_valid_out, 0);
      chk("ovf_sticky", tx_overflow_out, 1);

      rx_data_in = 8'h7E; rx_valid_in = 1'b1;
      #1 chk("rxr_idle", rx_ready_out, 0);
      drive(32'h0003_0000, 1'b0, 8'h00);
      #1 chk("rxr_pulse", rx_ready_out, 1);
      step();
      chk("rx_7e", mem_rdata_out, 8'h7E);
      drive(IDLE_A, 1'b0, 8'h00);
      #1 chk("rxr_drop", rx_ready_out, 0);
      rx_valid_in = 1'b0;
      drive(32'h0003_0000, 1'b0, 8'h00); step();
      chk("rx_none", mem_rdata_out, 8'h00);

      drive(32'h0003_0004, 1'b1, 8'h00); step();
      chk("stop_set", prog_stop_out, 1);
      drive(32'h0000_0010, 1'b0, 8'h00); step();
      chk("ram_reread", mem_rdata_out, 8'hA5);
      exp_cnt = mcnt;
      rdy_in = 1'b0; rx_valid_in = 1'b1;
      drive(32'h0003_0000, 1'b0, 8'h00);
      #1 chk("rxr_frozen", rx_ready_out, 0);
      drive(32'h0003_0000, 1'b1, 8'h55);
      repeat (5) step();
      chk("frz_rdata", mem_rdata_out, 8'hA5);
      chk("frz_nopush", tx_valid_out, 0);
      chk("frz_stop", prog_stop_out, 1);
      rdy_in = 1'b1; rx_valid_in = 1'b0;
      read_clk(got_w);
      chk("clk_frozen", got_w, exp_cnt);

      tx_ready_in = 1'b0;
      drive(32'h0003_0000, 1'b1, 8'h33); step();
      chk("pre_rst_txv", tx_valid_out, 1);
      rst_in = 1'b0; rx_valid_in = 1'b1;
      drive(32'h0003_0000, 1'b0, 8'h00); step();
      chk("rst2_rdata", mem_rdata_out, 0);
      chk("rst2_txv", tx_valid_out, 0);
      chk("rst2_txd", tx_data_out, 0);
      chk("rst2_stop", prog_stop_out, 0);
      chk("rst2_ovf", tx_overflow_out, 0);
      chk("rst2_rxr", rx_ready_out, 0);

      rst_in = 1'b1; rx_valid_in = 1'b0;
      idle(300);
      read_clk(got_w);
      chk("clk_snap300", got_w, 32'h0000_012C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
